// File: rtl/decode_issue.sv
// Decode/issue stage: decodes IF/ID, resolves RAW hazards, loads the ID/EX register.
// Optional macro DECODE_FORWARDING_EN enables EX/MEM/WB operand forwarding (default: stall-only).
module decode_issue (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifidValid,
  input  logic [15:0] ifidInstr,
  input  logic        flush,
  input  logic        exHold,
  output logic [3:0]  rAddr1,
  output logic [3:0]  rAddr2,
  input  logic [15:0] rData1,
  input  logic [15:0] rData2,
  input  logic [15:0] rData0,
  input  logic        exWrite,
  input  logic        exWrite0,
  input  logic        exIsLoad,
  input  logic [3:0]  exDest,
  input  logic [15:0] exData,
  input  logic [15:0] exData0,
  input  logic        memWrite,
  input  logic        memWrite0,
  input  logic [3:0]  memDest,
  input  logic [15:0] memData,
  input  logic [15:0] memData0,
  input  logic        wbWrite,
  input  logic        wbWrite0,
  input  logic [3:0]  wbDest,
  input  logic [15:0] wbData,
  input  logic [15:0] wbData0,
  output logic        stall,
  output logic        illegal,
  output logic        halted,
  output logic        idexValid,
  output logic [3:0]  idexOp,
  output logic [3:0]  idexFunc,
  output logic [3:0]  idexDest,
  output logic [15:0] idexA,
  output logic [15:0] idexB,
  output logic [15:0] idexR0,
  output logic [15:0] idexImm,
  output logic        idexRegWrite,
  output logic        idexRegWrite0,
  output logic        idexMemRead,
  output logic        idexMemWrite,
  output logic        idexBranch,
  output logic        idexHalt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  func;
    logic [3:0]  dest;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r0;
    logic [15:0] imm;
    logic        reg_write;
    logic        reg_write0;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        halt;
  } idex_t;

  state_t state_q, state_d;
  idex_t  idex_q, idex_d, dec;
  logic   illegal_q, illegal_d;

  logic [3:0] op, ra, rb, func;
  assign op     = ifidInstr[15:12];
  assign ra     = ifidInstr[11:8];
  assign rb     = ifidInstr[7:4];
  assign func   = ifidInstr[3:0];
  assign rAddr1 = ra;
  assign rAddr2 = rb;

  logic is_alu, is_lw, is_sw, is_br, is_jmp, is_halt, is_illegal;
  always_comb begin
    is_alu     = (op == 4'h0);
    is_lw      = (op == 4'h8);
    is_sw      = (op == 4'hB);
    is_br      = (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
    is_jmp     = (op == 4'hC);
    is_halt    = (op == 4'hF);
    is_illegal = !(is_alu || is_lw || is_sw || is_br || is_jmp || is_halt);
  end

  // Source slots: 0 = ra, 1 = rb, 2 = R0 (branch compare operand)
  logic [2:0]       used;
  logic [2:0][3:0]  src;
  logic [2:0][15:0] rf;
  logic [2:0]       hit_ex, hit_mem, hit_wb;
  logic [2:0][15:0] opnd;
  logic             hazard;

  assign used[0] = ifidValid && (is_alu || is_sw || is_br);
  assign used[1] = ifidValid && (is_alu || is_lw || is_sw);
  assign used[2] = ifidValid && is_br;
  assign src     = {4'd0, rb, ra};
  assign rf      = {rData0, rData2, rData1};

  // Register 0 is also written through the Write0 side channel (MUL/DIV)
  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    hit_wb  = '0;
    for (int i = 0; i < 3; i++) begin
      hit_ex[i]  = (exWrite  && exDest  == src[i]) || (exWrite0  && src[i] == 4'd0);
      hit_mem[i] = (memWrite && memDest == src[i]) || (memWrite0 && src[i] == 4'd0);
      hit_wb[i]  = (wbWrite  && wbDest  == src[i]) || (wbWrite0  && src[i] == 4'd0);
    end
  end

`ifdef DECODE_FORWARDING_EN
  logic [2:0]       hit_load;
  logic [2:0][15:0] fwd;
  always_comb begin
    hit_load = '0;
    fwd      = '0;
    for (int i = 0; i < 3; i++) begin
      hit_load[i] = exIsLoad && exWrite && (exDest == src[i]);
      if (hit_ex[i])
        fwd[i] = (exWrite0 && src[i] == 4'd0) ? exData0 : exData;
      else if (hit_mem[i])
        fwd[i] = (memWrite0 && src[i] == 4'd0) ? memData0 : memData;
      else if (hit_wb[i])
        fwd[i] = (wbWrite0 && src[i] == 4'd0) ? wbData0 : wbData;
      else
        fwd[i] = rf[i];
    end
  end
  assign hazard = |(used & hit_load);
  assign opnd   = fwd;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exIsLoad, exData, exData0, memData, memData0, wbData, wbData0};
  assign hazard = |(used & (hit_ex | hit_mem | hit_wb));
  assign opnd   = rf;
`endif

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    if (!is_illegal) begin
      dec.op   = op;
      dec.func = func;
      dec.dest = ra;
      dec.a    = opnd[0];
      dec.b    = opnd[1];
      dec.r0   = opnd[2];
    end
    dec.reg_write  = is_alu || is_lw;
    dec.reg_write0 = is_alu && (func == 4'h4 || func == 4'h5);
    dec.mem_read   = is_lw;
    dec.mem_write  = is_sw;
    dec.branch     = is_br || is_jmp;
    dec.halt       = is_halt;
    if (is_lw || is_sw)
      dec.imm = {{12{ifidInstr[3]}}, ifidInstr[3:0]};
    else if (is_br || is_jmp)
      dec.imm = {{8{ifidInstr[7]}}, ifidInstr[7:0]};
  end

  // Priority: flush > exHold > hazard bubble > issue; HALTED only emits bubbles
  always_comb begin
    state_d   = state_q;
    idex_d    = idex_q;
    illegal_d = 1'b0;
    stall     = 1'b0;
    if (state_q == HALTED) begin
      stall  = 1'b1;
      idex_d = '0;
    end else if (flush) begin
      idex_d = '0;
    end else if (exHold) begin
      stall = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      idex_d = '0;
    end else if (ifidValid) begin
      idex_d    = dec;
      illegal_d = is_illegal;
      if (is_halt) state_d = HALTED;
    end else begin
      idex_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
    end
  end

  assign halted        = (state_q == HALTED);
  assign illegal       = illegal_q;
  assign idexValid     = idex_q.valid;
  assign idexOp        = idex_q.op;
  assign idexFunc      = idex_q.func;
  assign idexDest      = idex_q.dest;
  assign idexA         = idex_q.a;
  assign idexB         = idex_q.b;
  assign idexR0        = idex_q.r0;
  assign idexImm       = idex_q.imm;
  assign idexRegWrite  = idex_q.reg_write;
  assign idexRegWrite0 = idex_q.reg_write0;
  assign idexMemRead   = idex_q.mem_read;
  assign idexMemWrite  = idex_q.mem_write;
  assign idexBranch    = idex_q.branch;
  assign idexHalt      = idex_q.halt;

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage of the 16-bit five-stage CPU, between the IF/ID register and the execute stage. Each cycle it decodes one 16-bit instruction, drives the register-file read addresses, resolves read-after-write hazards by forwarding or stalling, and loads the ID/EX pipeline register. It also owns the load-use bubble, branch flush squash and the sticky HALT state.

## Interface
Parameters:
- none; the datapath is fixed at 16 bits and 16 registers.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- ifidValid, ifidInstr  in  1, 16  instruction from IF/ID
- flush  in  1  branch taken in EX: squash the instruction in decode
- exHold  in  1  execute stage cannot accept: hold ID/EX
- rAddr1, rAddr2  out  4, 4  register-file read addresses, combinational from ifidInstr
- rData1, rData2, rData0  in  16 each  register-file read data; rData0 is always R0
- exWrite, exWrite0, exIsLoad, exDest, exData, exData0  in  1,1,1,4,16,16  instruction currently in EX
- memWrite, memWrite0, memDest, memData, memData0  in  1,1,4,16,16  instruction in MEM; load data is valid here
- wbWrite, wbWrite0, wbDest, wbData, wbData0  in  1,1,4,16,16  instruction in WB, written at the next edge
- stall  out  1  hold IF and IF/ID this cycle, combinational
- illegal  out  1  one-cycle pulse when an undefined opcode issues
- halted  out  1  sticky, set after HALT issues
- idexValid, idexOp, idexFunc, idexDest  out  1,4,4,4  registered
- idexA, idexB, idexR0, idexImm  out  16 each  registered operands
- idexRegWrite, idexRegWrite0, idexMemRead, idexMemWrite, idexBranch, idexHalt  out  1 each  registered controls

## Operation
Instruction fields: op=[15:12], ra=[11:8], rb=[7:4], func/imm4=[3:0], off8=[7:0].

- op 0x0 ALU: reads ra, rb; writes ra. func 0x4 (MUL) and 0x5 (DIV) also set RegWrite0. `idexImm`=0.
- op 0x8 LW: reads rb; writes ra; MemRead. `idexImm`=sext(imm4).
- op 0xB SW: reads ra, rb; MemWrite. `idexImm`=sext(imm4).
- op 0x4/0x5/0x6 BLT/BGT/BEQ: reads ra and R0; Branch. `idexImm`=sext(off8).
- op 0xC JMP: no reads; Branch. `idexImm`=sext(off8).
- op 0xF HALT: sets Halt.
- Any other op: issues as a NOP with all controls 0, idexValid=1, and pulses `illegal`.
- rAddr1=ra, rAddr2=rb. `idexA`/`idexB`/`idexR0` take the forwarded values of ra, rb and R0.

Forwarding, per used source s, highest priority first:
- EX, when exWrite and exDest==s.
- MEM, when memWrite and memDest==s.
- WB, when wbWrite and wbDest==s.
- Otherwise the register-file value.
- For the R0 operand, a stage also matches on its Write0 and then supplies its Data0.
- Within one stage, Write0 beats Write with dest 0.

Stall (combinational):
- stall = exHold, or load-use. Load-use is exIsLoad && exWrite && exDest equal to any used source of a valid decode instruction.
- On a load-use stall without exHold, ID/EX loads a bubble (idexValid=0, all controls 0).
- On exHold, ID/EX holds its contents.

Priority and state:
- Priority order: reset > flush > exHold > load-use > normal issue.
- flush loads a bubble even under exHold, and `stall` is forced to 0 that cycle.
- FSM states: RUN and HALTED. RUN goes to HALTED on the edge that issues HALT. HALTED is left only by reset.
- In HALTED, every cycle issues a bubble and `stall` stays 1.

## Timing
- Decode to ID/EX: 1 cycle. Forwarding and stall are same-cycle combinational.
- Load-use costs exactly 1 bubble.
- A WB write in the same cycle as the read is forwarded, because the register file does not update until the edge.
- Reset values: every idex* output 0, idexValid=0, halted=0, illegal=0. stall=0 (exHold=0).
- Reset mid-stall or in HALTED returns the block to RUN with an empty ID/EX.

## Configuration
- `DECODE_FORWARDING_EN` defined: forwarding as above.
- `DECODE_FORWARDING_EN` undefined: there is no forwarding and operands come straight from the register file. Stall is asserted whenever EX, MEM or WB has a matching Write or Write0 for a used source, giving up to 3 bubbles per dependency. The exHold, flush and HALT rules are unchanged.

## Test plan
- Reset: reset=0 mid-operation → all idex* outputs 0, halted=0; after release, ifidInstr=0x0120 (ALU r1,r2) with rData1=0x0F00, rData2=0x0050 → idexA=0x0F00, idexB=0x0050, idexRegWrite=1 one cycle later.
- Forwarding priority: source r2 with exDest=2/exData=0x1111, memDest=2/memData=0x2222, wbDest=2/wbData=0x3333 → idexB=0x1111. Remove EX → 0x2222. Remove MEM → 0x3333.
- Load-use: exIsLoad=1, exDest=3, decode 0x0130 → stall=1 for one cycle and a bubble in ID/EX. The next cycle issues with idexB=memData.
- R0 forwarding on BEQ: decode 0x6105, exWrite0=1, exData0=0xAAAA → idexR0=0xAAAA, idexImm=0x0005. Off8=0xFE → idexImm=0xFFFE.
- flush with exHold both high → idexValid=0, stall=0. exHold alone → ID/EX unchanged, stall=1.
- HALT 0xF000 → idexHalt=1, then halted=1 and stall=1 until reset. Opcode 0x3 → illegal pulses for one cycle. Without `DECODE_FORWARDING_EN`, a WB-only dependency → 1 stall cycle.
